// File: rtl/bin_to_gray.sv
// Registered binary-to-reflected-Gray converter with one cycle of latency.
// Define BIN2GRAY_DECODE_EN to add the registered Gray-to-binary self-check outputs.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] BIN,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] GRAY
`ifdef BIN2GRAY_DECODE_EN
  ,
  output logic [WIDTH-1:0] BIN_CHK,
  output logic             CHK_ERR
`endif
);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] gray_p0;
  logic             vld_p0;

  assign gray_next = to_gray(BIN);

  // Stage 0: capture the converted word; GRAY holds while IN_VALID is low
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gray_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= IN_VALID;
      if (IN_VALID) begin
        gray_p0 <= gray_next;
      end
    end
  end

  assign GRAY      = gray_p0;
  assign OUT_VALID = vld_p0;

`ifdef BIN2GRAY_DECODE_EN
  // Prefix XOR from the MSB down recovers the binary word from its Gray code.
  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_chk_next;
  logic [WIDTH-1:0] bin_chk_p0;
  logic             chk_err_p0;

  assign bin_chk_next = to_bin(gray_next);

  // Stage 0: decode registered alongside GRAY so the check lines up with it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bin_chk_p0 <= '0;
      chk_err_p0 <= 1'b0;
    end else begin
      chk_err_p0 <= IN_VALID && (bin_chk_next != BIN);
      if (IN_VALID) begin
        bin_chk_p0 <= bin_chk_next;
      end
    end
  end

  assign BIN_CHK = bin_chk_p0;
  assign CHK_ERR = chk_err_p0;
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Directed bench for bin_to_gray: a WIDTH=4 instance and a WIDTH=8 instance.
module tb_bin_to_gray;

  logic       CLK;
  logic       RST_N;
  logic       in_valid4;
  logic [3:0] bin4;
  logic       out_valid4;
  logic [3:0] gray4;
  logic       in_valid8;
  logic [7:0] bin8;
  logic       out_valid8;
  logic [7:0] gray8;
`ifdef BIN2GRAY_DECODE_EN
  logic [3:0] bin_chk4;
  logic       chk_err4;
  logic [7:0] bin_chk8;
  logic       chk_err8;
`endif

  int checks   = 0;
  int failures = 0;

  bin_to_gray #(.WIDTH(4)) dut4 (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (in_valid4),
    .BIN      (bin4),
    .OUT_VALID(out_valid4),
    .GRAY     (gray4)
`ifdef BIN2GRAY_DECODE_EN
    ,
    .BIN_CHK  (bin_chk4),
    .CHK_ERR  (chk_err4)
`endif
  );

  bin_to_gray #(.WIDTH(8)) dut8 (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (in_valid8),
    .BIN      (bin8),
    .OUT_VALID(out_valid8),
    .GRAY     (gray8)
`ifdef BIN2GRAY_DECODE_EN
    ,
    .BIN_CHK  (bin_chk8),
    .CHK_ERR  (chk_err8)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [3:0] SWEEP_EXP [18] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
    4'b0000, 4'b0001
  };

  localparam logic [7:0] W8_BIN [6] = '{8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h81, 8'h7F};
  localparam logic [7:0] W8_EXP [6] = '{8'h80, 8'h00, 8'hF7, 8'h22, 8'hC1, 8'h40};

  initial begin
    logic [3:0] prev_gray;
    logic [7:0] prev_bin8;
    RST_N     = 1'b1;
    in_valid4 = 1'b1;
    bin4      = 4'b1010;
    in_valid8 = 1'b0;
    bin8      = 8'h00;
    prev_gray = 4'b0000;
    prev_bin8 = 8'h00;

    // Asynchronous reset, checked before any clock edge
    #2 RST_N = 1'b0;
    #1;
    check("reset_gray", 32'(gray4), 32'h0);
    check("reset_vld", 32'(out_valid4), 32'h0);
`ifdef BIN2GRAY_DECODE_EN
    check("reset_bin_chk", 32'(bin_chk4), 32'h0);
    check("reset_chk_err", 32'(chk_err4), 32'h0);
`endif
    step();
    check("reset_hold_gray", 32'(gray4), 32'h0);
    check("reset_hold_vld", 32'(out_valid4), 32'h0);
    RST_N = 1'b1;

    // Single conversion
    in_valid4 = 1'b1;
    bin4      = 4'b0101;
    step();
    check("single_gray", 32'(gray4), 32'h7);
    check("single_vld", 32'(out_valid4), 32'h1);

    // Full sweep 0..15 then wrap to 0, 1
    for (int i = 0; i < 18; i++) begin
      bin4 = 4'(i);
      step();
      check($sformatf("sweep_gray_%0d", i), 32'(gray4), 32'(SWEEP_EXP[i]));
      check($sformatf("sweep_vld_%0d", i), 32'(out_valid4), 32'h1);
      if (i > 0) begin
        check($sformatf("sweep_onebit_%0d", i), 32'($countones(gray4 ^ prev_gray)), 32'h1);
      end
      prev_gray = gray4;
    end

    // Hold when IN_VALID drops
    bin4 = 4'b1111;
    step();
    check("hold_load_gray", 32'(gray4), 32'h8);
    in_valid4 = 1'b0;
    bin4      = 4'b0011;
    step();
    check("hold_gray", 32'(gray4), 32'h8);
    check("hold_vld", 32'(out_valid4), 32'h0);

    // Mid-stream reset at BIN=1001
    in_valid4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bin4 = 4'(i);
      step();
    end
    check("mid_pre_gray", 32'(gray4), 32'hD);
    #2 RST_N = 1'b0;
    #1;
    check("mid_reset_gray", 32'(gray4), 32'h0);
    check("mid_reset_vld", 32'(out_valid4), 32'h0);
    RST_N = 1'b1;
    bin4  = 4'b0010;
    step();
    check("mid_after_gray", 32'(gray4), 32'h3);
    check("mid_after_vld", 32'(out_valid4), 32'h1);
    in_valid4 = 1'b0;

    // WIDTH=8 directed vectors
    in_valid8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bin8 = W8_BIN[i];
      step();
      check($sformatf("w8_gray_%0h", W8_BIN[i]), 32'(gray8), 32'(W8_EXP[i]));
      check($sformatf("w8_vld_%0h", W8_BIN[i]), 32'(out_valid8), 32'h1);
`ifdef BIN2GRAY_DECODE_EN
      check($sformatf("w8_bin_chk_%0h", W8_BIN[i]), 32'(bin_chk8), 32'(W8_BIN[i]));
      check($sformatf("w8_chk_err_%0h", W8_BIN[i]), 32'(chk_err8), 32'h0);
`endif
    end

`ifdef BIN2GRAY_DECODE_EN
    // Random words: decode must return the word sampled one cycle earlier
    for (int i = 0; i < 40; i++) begin
      prev_bin8 = 8'($urandom_range(0, 255));
      bin8      = prev_bin8;
      step();
      check($sformatf("rnd_bin_chk_%0d", i), 32'(bin_chk8), 32'(prev_bin8));
      check($sformatf("rnd_chk_err_%0d", i), 32'(chk_err8), 32'h0);
    end
    in_valid8 = 1'b0;
    bin8      = 8'h12;
    step();
    check("rnd_hold_bin_chk", 32'(bin_chk8), 32'(prev_bin8));
    check("rnd_hold_chk_err", 32'(chk_err8), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
